modport_wdog: RTL and testbench
===============================

# modport_wdog

APB-programmable watchdog timer with a 32-bit down-counter, a maskable interrupt and a reset-request output. It sits on the peripheral APB bus and drives the system interrupt controller (`WDOGINT`) and the system reset generator (`WDOGRES`). Counting is paced by a clock-enable strobe (`WDOGCLKEN`), so the block runs entirely on a single clock.

## Interface

- Parameters: none.
- `PCLK` in 1: the only clock; all logic is on the rising edge.
- `PRESETn` in 1: reset, synchronous, active-low; clears all registers.
- `WDOGRSTn` in 1: watchdog-logic reset, synchronous, active-low.
  - Clears the counter, interrupt and reset-request state.
  - Does not affect `WDOGLOAD`, `WDOGCONTROL`, the lock or integration registers.
- `WDOGCLKEN` in 1: counter tick enable; one decrement per `PCLK` edge where it is 1.
- `PSEL`, `PENABLE`, `PWRITE` in 1 each: APB control.
- `PADDR` in 32: byte address; only bits [11:2] are decoded.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: tied to 1; no wait states.
- `WDOGINT` out 1: interrupt, active-high.
- `WDOGRES` out 1: reset request, active-high.

## Operation

- Register map (offsets):
  - 0x000 `LOAD`: RW, reset 0xFFFFFFFF. Writing it also reloads the counter.
  - 0x004 `VALUE`: RO, current counter value, reset 0xFFFFFFFF.
  - 0x008 `CONTROL`: RW [1:0], reset 0. Bit 0 = `INTEN`, bit 1 = `RESEN`.
  - 0x00C `INTCLR`: WO. Any write clears `RIS` and reloads the counter from `LOAD`.
  - 0x010 `RIS`: RO bit 0, raw interrupt status.
  - 0x014 `MIS`: RO bit 0, equal to `RIS & INTEN`.
  - 0xC00 `LOCK`: writing 0x1ACCE551 unlocks; writing any other value locks. Reads return bit 0 = locked. Reset state is unlocked.
  - 0xF00 `ITCR`: RW bit 0, integration test mode, reset 0.
  - 0xF04 `ITOP`: WO [1:0]; bit 1 = `WDOGRES` value, bit 0 = `WDOGINT` value; reset 0.
  - 0xFD0–0xFFC ID registers (RO, bits [7:0]): PID4..7 = 04,00,00,00; PID0..3 = 24,B8,1B,00; CID0..3 = 0D,F0,05,B1.
  - Unmapped offsets read 0; writes to them are ignored.
- While locked, writes to every register except `LOCK` are ignored.
- Counting occurs only when `INTEN` = 1 and `WDOGCLKEN` = 1.
  - `VALUE` ≠ 0: decrement by 1.
  - `VALUE` = 0 (expiry): reload from `LOAD`.
    - If `RIS` = 0, set `RIS` = 1.
    - If `RIS` was already 1 and `RESEN` = 1, set the `WDOGRES` latch to 1.
- A write that changes `INTEN` from 0 to 1 reloads the counter from `LOAD`.
- The `WDOGRES` latch is sticky. Only `PRESETn` or `WDOGRSTn` clears it.
- Outputs in normal mode: `WDOGINT = RIS & INTEN`, `WDOGRES` = latch.
- Outputs in integration mode (`ITCR[0]` = 1): `WDOGINT = ITOP[0]`, `WDOGRES = ITOP[1]`. Counter and status logic keep running.
- Write priority within one edge:
  - `LOAD`/`INTCLR` reload beats a decrement.
  - An `INTCLR` write beats a simultaneous expiry setting `RIS`. The clear wins, and no reset request is raised on that edge.

## Timing

- A write takes effect on the `PCLK` edge of the access phase (`PSEL & PENABLE & PWRITE`).
- Reads:
  - `PRDATA` is registered on the setup-phase edge (`PSEL & !PENABLE & !PWRITE`).
  - It is valid throughout the access phase.
  - It is 0 whenever no read is in progress.
- Interrupt period:
  - After a reload of value N, `RIS` rises on the (N+1)th enabled tick.
  - `WDOGINT` is high from the edge after that tick.
- Reset request:
  - With `RIS` left set and `RESEN` = 1, `WDOGRES` rises N+1 ticks after the first expiry.
- Reset values: all outputs 0, `PREADY` = 1, `VALUE` = 0xFFFFFFFF.
- `WDOGRSTn` low mid-count: on that edge, `VALUE` ← `LOAD` and `RIS` ← 0. `WDOGRES` clears on the same edge.
- Boundary behaviour:
  - `LOAD` = 0: expiry occurs on every enabled tick.
  - `WDOGCLKEN` = 0: the counter holds.
  - No wrap below 0.

## Test plan

- Reset:
  - Read `LOAD` and `VALUE` → 0xFFFFFFFF each.
  - Read `CONTROL`, `RIS`, `MIS`, `LOCK`, `ITCR` → 0 each.
  - `WDOGINT` = `WDOGRES` = 0.
- Interrupt timing:
  - Write `LOAD` = 4, `CONTROL` = 1, `WDOGCLKEN` = 1 constantly.
  - Expect `WDOGINT` = 1 after 5 ticks and `RIS` = `MIS` = 1.
  - Write `INTCLR` → `WDOGINT` = 0 and `VALUE` = 4.
- Reset request:
  - Write `LOAD` = 3, `CONTROL` = 3, never clear the interrupt.
  - Expect `WDOGINT` after 4 ticks and `WDOGRES` after 8 ticks.
  - `WDOGRES` stays 1 until `WDOGRSTn` is pulsed.
- Lock:
  - Write `LOCK` = 0 → read `LOCK` = 1.
  - Write `LOAD` = 5 → `LOAD` unchanged.
  - Write `LOCK` = 0x1ACCE551, then `LOAD` = 5 → read back 5.
- Integration test:
  - Write `ITCR` = 1, `ITOP` = 2 → `WDOGRES` = 1, `WDOGINT` = 0.
  - Write `ITCR` = 0 → outputs return to normal mode.
- Clock-enable gating and ID registers:
  - With `WDOGCLKEN` toggling every other cycle and `LOAD` = 10, the interrupt fires after 11 enabled ticks (22 cycles).
  - Read 0xFE0 → 0x24, 0xFFC → 0xB1.

Source files
------------

// File: rtl/modport_wdog_if.sv
// APB bus bundle for the watchdog: the bus master drives the request side and
// the watchdog returns read data and a permanently-high ready.
interface modport_wdog_if;
  // Handshake: an access starts with psel high and penable low (setup); the
  // next cycle raises penable (access) and completes on that edge because
  // pready is always 1, so no transfer ever stalls.
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/modport_wdog.sv
// APB watchdog: 32-bit down-counter paced by a clock-enable strobe, raising an
// interrupt on first expiry and a sticky reset request on a second unserviced one.
module modport_wdog (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          wdogrstn,
  input  logic          wdogclken,
  modport_wdog_if.slave apb,
  output logic          wdogint,
  output logic          wdogres
);

  localparam logic [9:0]  OFF_LOAD    = 10'h000;
  localparam logic [9:0]  OFF_VALUE   = 10'h001;
  localparam logic [9:0]  OFF_CONTROL = 10'h002;
  localparam logic [9:0]  OFF_INTCLR  = 10'h003;
  localparam logic [9:0]  OFF_RIS     = 10'h004;
  localparam logic [9:0]  OFF_MIS     = 10'h005;
  localparam logic [9:0]  OFF_LOCK    = 10'h300;
  localparam logic [9:0]  OFF_ITCR    = 10'h3c0;
  localparam logic [9:0]  OFF_ITOP    = 10'h3c1;
  localparam logic [31:0] UNLOCK_KEY  = 32'h1acc_e551;

  logic [9:0]  off;
  logic        wr_acc;
  logic        rd_setup;
  logic        rd_acc;
  logic        wr_en;
  logic        lock_wr;

  logic [31:0] load_q;
  logic [31:0] value_q;
  logic        inten;
  logic        resen;
  logic        ris;
  logic        res_q;
  logic        locked;
  logic        itcr;
  logic [1:0]  itop;
  logic [31:0] prdata_q;
  logic [31:0] rdata;

  logic        load_wr;
  logic        intclr_wr;
  logic        inten_rise;
  logic        tick;
  logic        expire;

  logic        unused_paddr;
  assign unused_paddr = &{1'b0, apb.paddr[31:12], apb.paddr[1:0]};

  assign off      = apb.paddr[11:2];
  assign wr_acc   = apb.psel & apb.penable & apb.pwrite;
  assign rd_setup = apb.psel & ~apb.penable & ~apb.pwrite;
  assign rd_acc   = apb.psel & apb.penable & ~apb.pwrite;
  // The lock register stays writable while locked so software can unlock.
  assign wr_en    = wr_acc & ~locked;
  assign lock_wr  = wr_acc & (off == OFF_LOCK);

  assign load_wr    = wr_en & (off == OFF_LOAD);
  assign intclr_wr  = wr_en & (off == OFF_INTCLR);
  assign inten_rise = wr_en & (off == OFF_CONTROL) & apb.pwdata[0] & ~inten;
  assign tick       = inten & wdogclken;
  assign expire     = tick & (value_q == 32'd0);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      load_q <= 32'hffff_ffff;
      inten  <= 1'b0;
      resen  <= 1'b0;
      locked <= 1'b0;
      itcr   <= 1'b0;
      itop   <= 2'b00;
    end else begin
      if (lock_wr) locked <= (apb.pwdata != UNLOCK_KEY);
      if (wr_en) begin
        case (off)
          OFF_LOAD:    load_q <= apb.pwdata;
          OFF_CONTROL: begin
            inten <= apb.pwdata[0];
            resen <= apb.pwdata[1];
          end
          OFF_ITCR:    itcr <= apb.pwdata[0];
          OFF_ITOP:    itop <= apb.pwdata[1:0];
          default:     ;
        endcase
      end
    end
  end

  // Counter and status: explicit reloads beat the decrement, and a clear beats
  // a coincident expiry (no reset request is raised on that edge either).
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      value_q <= 32'hffff_ffff;
      ris     <= 1'b0;
      res_q   <= 1'b0;
    end else if (!wdogrstn) begin
      value_q <= load_q;
      ris     <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      if (load_wr)
        value_q <= apb.pwdata;
      else if (intclr_wr || inten_rise)
        value_q <= load_q;
      else if (tick)
        value_q <= (value_q == 32'd0) ? load_q : value_q - 32'd1;

      if (intclr_wr)
        ris <= 1'b0;
      else if (expire)
        ris <= 1'b1;

      if (expire && ris && resen && !intclr_wr)
        res_q <= 1'b1;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (off)
      OFF_LOAD:    rdata = load_q;
      OFF_VALUE:   rdata = value_q;
      OFF_CONTROL: rdata = {30'd0, resen, inten};
      OFF_RIS:     rdata = {31'd0, ris};
      OFF_MIS:     rdata = {31'd0, ris & inten};
      OFF_LOCK:    rdata = {31'd0, locked};
      OFF_ITCR:    rdata = {31'd0, itcr};
      10'h3f4:     rdata = 32'h04;
      10'h3f8:     rdata = 32'h24;
      10'h3f9:     rdata = 32'hb8;
      10'h3fa:     rdata = 32'h1b;
      10'h3fc:     rdata = 32'h0d;
      10'h3fd:     rdata = 32'hf0;
      10'h3fe:     rdata = 32'h05;
      10'h3ff:     rdata = 32'hb1;
      default:     rdata = 32'd0;
    endcase
  end

  // Read data is captured in setup, held through access, and zero otherwise.
  always_ff @(posedge pclk) begin
    if (!presetn)
      prdata_q <= 32'd0;
    else if (rd_setup)
      prdata_q <= rdata;
    else if (!rd_acc)
      prdata_q <= 32'd0;
  end

  assign apb.prdata = prdata_q;
  assign apb.pready = 1'b1;

  assign wdogint = itcr ? itop[0] : (ris & inten);
  assign wdogres = itcr ? itop[1] : res_q;

endmodule

// File: tb/tb_modport_wdog.sv
// Directed bench for modport_wdog: drivers push expected read data or pin
// states into a queue, and a negedge monitor pops and compares them.
module tb_modport_wdog;

  logic pclk;
  logic presetn;
  logic wdogrstn;
  logic wdogclken;
  logic wdogint;
  logic wdogres;
  logic probe;

  modport_wdog_if bus ();

  modport_wdog dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .wdogrstn  (wdogrstn),
    .wdogclken (wdogclken),
    .apb       (bus.slave),
    .wdogint   (wdogint),
    .wdogres   (wdogres)
  );

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          tests;
  int          fails;

  // clock/reset
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish (tests=%0d)", tests);
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.pwrite = 1'b1; bus.penable = 1'b0;
    bus.paddr = addr; bus.pwdata = data;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.penable = 1'b0; bus.paddr = addr;
    @(posedge pclk); #1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    bus.penable = 1'b1;
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic check_pins(input logic exp_int, input logic exp_res, input string name);
    @(posedge pclk); #1;
    exp_q.push_back({30'd0, exp_res, exp_int});
    name_q.push_back(name);
    probe = 1'b1;
    @(posedge pclk); #1;
    probe = 1'b0;
  endtask

  task automatic ticks(input int n);
    @(posedge pclk); #1;
    wdogclken = 1'b1;
    repeat (n) @(posedge pclk);
    #1 wdogclken = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge pclk) begin
    if (presetn && ((bus.psel && bus.penable && !bus.pwrite) || probe)) begin
      logic [31:0] act;
      act = probe ? {30'd0, wdogres, wdogint} : bus.prdata;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %h with empty expected queue", act);
      end else begin
        logic [31:0] exp;
        string nm;
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        if (act !== exp) begin
          fails++;
          $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
      end
    end
  end

  initial begin
    tests = 0; fails = 0;
    presetn = 1'b0; wdogrstn = 1'b1; wdogclken = 1'b0; probe = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 32'd0; bus.pwdata = 32'd0;
    repeat (4) @(posedge pclk);
    #1 presetn = 1'b1;

    // reset state
    apb_read(32'h000, 32'hffff_ffff, "rst_load");
    apb_read(32'h004, 32'hffff_ffff, "rst_value");
    apb_read(32'h008, 32'd0, "rst_control");
    apb_read(32'h010, 32'd0, "rst_ris");
    apb_read(32'h014, 32'd0, "rst_mis");
    apb_read(32'hc00, 32'd0, "rst_lock");
    apb_read(32'hf00, 32'd0, "rst_itcr");
    check_pins(1'b0, 1'b0, "rst_pins");

    // interrupt timing: LOAD=4 fires on the 5th tick
    apb_write(32'h000, 32'd4);
    apb_write(32'h008, 32'd1);
    ticks(4);
    check_pins(1'b0, 1'b0, "int_before_5th_tick");
    ticks(1);
    check_pins(1'b1, 1'b0, "int_after_5th_tick");
    apb_read(32'h010, 32'd1, "int_ris");
    apb_read(32'h014, 32'd1, "int_mis");
    ticks(2);
    apb_read(32'h004, 32'd2, "int_value_counting");
    apb_write(32'h00c, 32'd0);
    check_pins(1'b0, 1'b0, "intclr_pins");
    apb_read(32'h004, 32'd4, "intclr_reload");

    // reset request: LOAD=3, INTEN+RESEN, never cleared
    apb_write(32'h000, 32'd3);
    apb_write(32'h008, 32'd3);
    ticks(3);
    check_pins(1'b0, 1'b0, "res_3_ticks");
    ticks(1);
    check_pins(1'b1, 1'b0, "res_4_ticks");
    ticks(3);
    check_pins(1'b1, 1'b0, "res_7_ticks");
    ticks(1);
    check_pins(1'b1, 1'b1, "res_8_ticks");
    ticks(5);
    check_pins(1'b1, 1'b1, "res_sticky");
    @(posedge pclk); #1 wdogrstn = 1'b0;
    @(posedge pclk); #1 wdogrstn = 1'b1;
    check_pins(1'b0, 1'b0, "wdogrstn_clears");
    apb_read(32'h004, 32'd3, "wdogrstn_value");
    apb_read(32'h008, 32'd3, "wdogrstn_keeps_control");

    // clock-enable gating: LOAD=10, enable every other cycle
    apb_write(32'h000, 32'd10);
    apb_write(32'h008, 32'd1);
    @(posedge pclk); #1;
    for (int i = 0; i < 20; i++) begin
      wdogclken = (i % 2 == 0);
      @(posedge pclk); #1;
    end
    wdogclken = 1'b0;
    check_pins(1'b0, 1'b0, "gate_10_ticks");
    for (int i = 0; i < 2; i++) begin
      wdogclken = (i == 0);
      @(posedge pclk); #1;
    end
    wdogclken = 1'b0;
    check_pins(1'b1, 1'b0, "gate_11_ticks");
    apb_read(32'h004, 32'd10, "gate_value_reload");

    // lock
    apb_write(32'hc00, 32'd0);
    apb_read(32'hc00, 32'd1, "lock_set");
    apb_write(32'h000, 32'd5);
    apb_read(32'h000, 32'd10, "locked_load");
    apb_write(32'hc00, 32'h1acc_e551);
    apb_read(32'hc00, 32'd0, "lock_clear");
    apb_write(32'h000, 32'd5);
    apb_read(32'h000, 32'd5, "unlocked_load");

    // integration mode
    apb_write(32'hf00, 32'd1);
    apb_write(32'hf04, 32'd2);
    check_pins(1'b0, 1'b1, "itop_pins");
    apb_read(32'hf00, 32'd1, "itcr_read");
    apb_write(32'hf00, 32'd0);
    check_pins(1'b1, 1'b0, "itcr_off_pins");

    // LOAD=0 expires on every enabled tick
    apb_write(32'h00c, 32'd0);
    apb_write(32'h000, 32'd0);
    check_pins(1'b0, 1'b0, "load0_before");
    ticks(1);
    check_pins(1'b1, 1'b0, "load0_one_tick");

    // ID and unmapped registers
    apb_read(32'hfe0, 32'h24, "pid0");
    apb_read(32'hffc, 32'hb1, "cid3");
    apb_read(32'hfd0, 32'h04, "pid4");
    apb_read(32'h020, 32'd0, "unmapped");

    repeat (3) @(posedge pclk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d expected entries left, 0 required", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
